// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU requester: opcodes, the buffered
// request record, the ALU's fixed latency and the requester FSM encoding.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND    = 4'b0000,
        ALU_OR     = 4'b0001,
        ALU_NOT    = 4'b0010,
        ALU_ADD    = 4'b0011,
        ALU_SUB    = 4'b0100,
        ALU_INC    = 4'b0101,
        ALU_SHL    = 4'b0110,
        ALU_SHR    = 4'b0111,
        ALU_POPCNT = 4'b1000
    } alu_op_t;

    // Width of the tag field carried through the request FIFO.
    localparam int unsigned REQ_TAG_W   = 4;
    localparam int unsigned ALU_LATENCY = 5;

    typedef struct packed {
        logic [63:0]          a;
        logic [63:0]          b;
        alu_op_t              op;
        logic [REQ_TAG_W-1:0] tag;
    } alu_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } req_state_t;

endpackage

// File: rtl/alu_requester_if.sv
// Request, ALU and response signals of the requester; slave is the requester's
// own view, master the view of the surrounding sequencer/ALU/consumer.
interface alu_requester_if #(
    parameter int unsigned TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [63:0]      req_a;
    logic [63:0]      req_b;
    logic [3:0]       req_op;
    logic [TAG_W-1:0] req_tag;

    logic             alu_valid;
    logic [63:0]      alu_a;
    logic [63:0]      alu_b;
    logic [3:0]       alu_op;
    logic [63:0]      alu_z;
    logic             alu_done;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_z;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic             err_sticky;

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag,
        output req_ready,
        output alu_valid, alu_a, alu_b, alu_op,
        input  alu_z, alu_done,
        output rsp_valid, rsp_z, rsp_tag, rsp_err, err_sticky,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_op, req_tag,
        input  req_ready,
        input  alu_valid, alu_a, alu_b, alu_op,
        output alu_z, alu_done,
        input  rsp_valid, rsp_z, rsp_tag, rsp_err, err_sticky,
        output rsp_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; the head entry is presented
// combinationally on rd_data_o whenever the FIFO is non-empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty after wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage write; contents need no reset since empty_o masks stale entries.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/alu_requester.sv
// Initiator for the multi-cycle ALU: buffers requests, issues them one at a
// time with a single-cycle valid pulse and returns tagged results in order.
module alu_requester
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = REQ_TAG_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    alu_requester_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam int unsigned REQ_W = $bits(alu_req_t);

    req_state_t       state_q;
    logic             alu_valid_q;
    logic             rsp_valid_q;
    logic [63:0]      rsp_z_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic             rsp_err_q;
    logic             err_sticky_q;
    logic [CNT_W-1:0] wait_cnt_q;

    alu_req_t         wr_req_s;
    alu_req_t         head_s;
    logic [REQ_W-1:0] head_bits_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;

    assign wr_req_s = '{a:   bus.req_a,
                        b:   bus.req_b,
                        op:  alu_op_t'(bus.req_op),
                        tag: REQ_TAG_W'(bus.req_tag)};
    assign push_s      = bus.req_valid && !full_s;
    assign pop_s       = (state_q == ST_ISSUE);
    assign head_s      = alu_req_t'(head_bits_s);

    sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push_s),
        .wr_data_i (wr_req_s),
        .pop_i     (pop_s),
        .rd_data_o (head_bits_s),
        .full_o    (full_s),
        .empty_o   (empty_s)
    );

    assign bus.req_ready  = !full_s;
    assign bus.alu_valid  = alu_valid_q;
    assign bus.alu_a      = head_s.a;
    assign bus.alu_b      = head_s.b;
    assign bus.alu_op     = head_s.op;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_z      = rsp_z_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.err_sticky = err_sticky_q;

    // Issue/wait/respond sequencer; alu_done is only honoured in ST_WAIT so a
    // strobe arriving after a timeout is silently dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            alu_valid_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_z_q      <= 64'd0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty_s) begin
                        state_q     <= ST_ISSUE;
                        alu_valid_q <= 1'b1;
                    end else begin
                        alu_valid_q <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    alu_valid_q <= 1'b0;
                    rsp_tag_q   <= TAG_W'(head_s.tag);
                    wait_cnt_q  <= '0;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.alu_done) begin
                        rsp_z_q     <= bus.alu_z;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        rsp_z_q      <= 64'd0;
                        rsp_err_q    <= 1'b1;
                        err_sticky_q <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    alu_valid_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_requester.sv
// Randomized and directed bench for alu_requester with a behavioural ALU and
// an in-order scoreboard of accepted requests.
module tb_alu_requester;
    import alu_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned TIMEOUT = 16;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic stub = 1'b0;
    always #5 clk = ~clk;

    alu_requester_if #(.TAG_W(TAG_W)) bus ();

    alu_requester #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return ~a;
            4'd3:    return a + b;
            4'd4:    return a - b;
            4'd5:    return a + 64'd1;
            4'd6:    return a << b[5:0];
            4'd7:    return a >> b[5:0];
            default: return 64'($countones(a));
        endcase
    endfunction

    // Behavioural ALU: result strobe ALU_LATENCY cycles after acceptance.
    int          alu_cnt;
    logic [63:0] alu_a_l, alu_b_l;
    logic [3:0]  alu_op_l;
    always @(posedge clk) begin
        if (rst) begin
            alu_cnt      <= 0;
            bus.alu_done <= 1'b0;
            bus.alu_z    <= 64'd0;
        end else begin
            bus.alu_done <= 1'b0;
            if (bus.alu_valid) begin
                alu_cnt  <= ALU_LATENCY - 1;
                alu_a_l  <= bus.alu_a;
                alu_b_l  <= bus.alu_b;
                alu_op_l <= bus.alu_op;
            end else if (alu_cnt != 0) begin
                alu_cnt <= alu_cnt - 1;
                if (alu_cnt == 1 && !stub) begin
                    bus.alu_done <= 1'b1;
                    bus.alu_z    <= alu_ref(alu_op_l, alu_a_l, alu_b_l);
                end
            end
        end
    end

    typedef struct {
        logic [63:0]      a;
        logic [63:0]      b;
        logic [3:0]       op;
        logic [TAG_W-1:0] tag;
    } req_t;

    req_t exp_q[$];
    int   cyc = 0;
    int   alu_pulses = 0;
    int   alu_cyc = 0;
    int   rsp_count = 0;
    logic saw_stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every accepted request must come back, in order, exactly once.
    initial begin
        req_t r;
        logic [63:0] ez;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
            end else begin
                if (bus.alu_valid) begin
                    alu_pulses++;
                    alu_cyc = cyc;
                end
                if (bus.req_valid && bus.req_ready) begin
                    r = '{a: bus.req_a, b: bus.req_b, op: bus.req_op, tag: bus.req_tag};
                    exp_q.push_back(r);
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    rsp_count++;
                    if (exp_q.size() == 0) begin
                        check_eq("rsp_unexpected", 64'd1, 64'd0);
                    end else begin
                        r  = exp_q.pop_front();
                        ez = stub ? 64'd0 : alu_ref(r.op, r.a, r.b);
                        check_eq("rsp_z", bus.rsp_z, ez);
                        check_eq("rsp_tag", 64'(bus.rsp_tag), 64'(r.tag));
                        check_eq("rsp_err", 64'(bus.rsp_err), 64'(stub));
                    end
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] tag, output int t_hs);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        t_hs = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                t_hs = cyc;
                break;
            end
            saw_stall = 1'b1;
        end
        @(posedge clk);
        #1;
        if (t_hs < 0) check_eq("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_rsp(output int t);
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check_eq("rsp_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_one(input string name, input logic [3:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [TAG_W-1:0] tag, input logic [63:0] exp_z);
        int t0, t1;
        send(op, a, b, tag, t0);
        bus.req_valid = 1'b0;
        wait_rsp(t1);
        check_eq(name, bus.rsp_z, exp_z);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_count(input int target);
        for (int i = 0; i < 400 && rsp_count < target; i++) begin
            @(posedge clk);
        end
        #1;
        check_eq("rsp_count", 64'(rsp_count), 64'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t0, t1, p0, c0;
        logic sent_done;
        bus.req_valid = 1'b0;
        bus.req_a     = 64'd0;
        bus.req_b     = 64'd0;
        bus.req_op    = 4'd0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset_alu_valid", 64'(bus.alu_valid), 64'd0);
        check_eq("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("reset_req_ready", 64'(bus.req_ready), 64'd1);
        check_eq("reset_rsp_z", bus.rsp_z, 64'd0);
        check_eq("reset_sticky", 64'(bus.err_sticky), 64'd0);

        // Single ADD: latency and the one-cycle issue pulse.
        p0 = alu_pulses;
        send(ALU_ADD, 64'd5, 64'd7, 4'd3, t0);
        bus.req_valid = 1'b0;
        wait_rsp(t1);
        check_eq("add_latency", 64'(t1 - t0), 64'd8);
        check_eq("add_z", bus.rsp_z, 64'd12);
        check_eq("add_tag", 64'(bus.rsp_tag), 64'd3);
        check_eq("add_err", 64'(bus.rsp_err), 64'd0);
        @(posedge clk);
        #1;
        check_eq("add_issue_pulses", 64'(alu_pulses - p0), 64'd1);
        check_eq("add_issue_cycle", 64'(alu_cyc - t0), 64'd2);

        run_one("shr_z", ALU_SHR, 64'h80, 64'h43, 4'd1, 64'h10);
        run_one("sub_z", ALU_SUB, 64'd0, 64'd1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        run_one("popcnt_z", ALU_POPCNT, 64'hFF00, 64'd0, 4'd4, 64'd8);
        run_one("not_z", ALU_NOT, 64'd0, 64'd0, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF);

        // Back-to-back burst deeper than the FIFO.
        c0 = rsp_count;
        saw_stall = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom}, TAG_W'(k), t0);
        end
        bus.req_valid = 1'b0;
        check_eq("burst_stall", 64'(saw_stall), 64'd1);
        wait_count(c0 + 6);

        // Backpressure: response held stable, no reissue while stalled.
        bus.rsp_ready = 1'b0;
        c0 = rsp_count;
        send(ALU_SHL, 64'd1, 64'd4, 4'd7, t0);
        send(ALU_INC, 64'd41, 64'd0, 4'd8, t0);
        bus.req_valid = 1'b0;
        wait_rsp(t1);
        p0 = alu_pulses;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 64'(bus.rsp_valid), 64'd1);
            check_eq("hold_z", bus.rsp_z, 64'd16);
            check_eq("hold_tag", 64'(bus.rsp_tag), 64'd7);
        end
        @(posedge clk);
        #1;
        check_eq("hold_no_issue", 64'(alu_pulses - p0), 64'd0);
        bus.rsp_ready = 1'b1;
        wait_count(c0 + 2);

        // Randomized traffic with random response backpressure.
        sent_done = 1'b0;
        fork
            begin
                int th;
                for (int k = 0; k < 40; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom}, TAG_W'(k), th);
                    bus.req_valid = 1'b0;
                end
                sent_done = 1'b1;
            end
            begin
                for (int i = 0; i < 4000 && !(sent_done && exp_q.size() == 0); i++) begin
                    @(posedge clk);
                    #1;
                    bus.rsp_ready = 1'($urandom_range(0, 1));
                end
                bus.rsp_ready = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        check_eq("random_drain", 64'(exp_q.size()), 64'd0);

        // Timeout with a silent ALU, then reset mid-WAIT.
        stub = 1'b1;
        send(ALU_ADD, 64'd1, 64'd2, 4'd9, t0);
        bus.req_valid = 1'b0;
        wait_rsp(t1);
        check_eq("timeout_latency", 64'(t1 - t0), 64'd19);
        check_eq("timeout_err", 64'(bus.rsp_err), 64'd1);
        check_eq("timeout_z", bus.rsp_z, 64'd0);
        check_eq("timeout_sticky", 64'(bus.err_sticky), 64'd1);
        @(posedge clk);
        #1;
        send(ALU_ADD, 64'd3, 64'd4, 4'd10, t0);
        bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("midrst_alu_valid", 64'(bus.alu_valid), 64'd0);
        check_eq("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("midrst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check_eq("midrst_sticky", 64'(bus.err_sticky), 64'd0);
        check_eq("midrst_rsp_z", bus.rsp_z, 64'd0);
        check_eq("midrst_rsp_tag", 64'(bus.rsp_tag), 64'd0);
        check_eq("midrst_req_ready", 64'(bus.req_ready), 64'd1);
        c0 = rsp_count;
        p0 = alu_pulses;
        repeat (40) @(posedge clk);
        #1;
        check_eq("midrst_no_rsp", 64'(rsp_count - c0), 64'd0);
        check_eq("midrst_no_issue", 64'(alu_pulses - p0), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
